// File: rtl/dbus_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : dbus_responder_if
//  Purpose  : Data-bus request/response bundle between an initiator and a
//             dbus_responder memory model.
//  Revision : 1.0 - initial release
// ============================================================================
interface dbus_responder_if #(
    parameter int DMEM_WIDTH     = 128,
    parameter int DMEM_ADDRWIDTH = 32
);
    logic [DMEM_ADDRWIDTH-1:0] dbus_address;
    logic [DMEM_WIDTH-1:0]     dbus_writedata;
    logic [DMEM_WIDTH/8-1:0]   dbus_byteen;
    logic                      dbus_en;
    logic                      dbus_wren;
    logic                      dbus_prefetch;
    logic                      dbus_wait;
    logic                      dbus_data_valid;
    logic [DMEM_WIDTH-1:0]     dbus_readdata;

    modport master (
        output dbus_address, dbus_writedata, dbus_byteen,
        output dbus_en, dbus_wren, dbus_prefetch,
        input  dbus_wait, dbus_data_valid, dbus_readdata
    );

    modport slave (
        input  dbus_address, dbus_writedata, dbus_byteen,
        input  dbus_en, dbus_wren, dbus_prefetch,
        output dbus_wait, dbus_data_valid, dbus_readdata
    );
endinterface
`default_nettype wire

// File: rtl/dbus_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dbus_responder
//  Purpose  : Fixed-latency word memory answering data-bus reads, writes and
//             prefetch hints, one request at a time.
//  Revision : 1.0 - initial release
// ============================================================================
module dbus_responder #(
    parameter int DMEM_WIDTH     = 128,
    parameter int DMEM_ADDRWIDTH = 32,
    parameter int DEPTH_LOG2     = 8,
    parameter int RD_LATENCY     = 3,
    parameter int WR_LATENCY     = 2
) (
    input  logic             clk,
    input  logic             resetn,
    dbus_responder_if.slave  dbus
);
    localparam int         c_BYTES   = DMEM_WIDTH / 8;
    localparam int         c_OFFSET  = (c_BYTES > 1) ? $clog2(c_BYTES) : 0;
    localparam int         c_DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [3:0] c_RD_LOAD = 4'(RD_LATENCY - 1);
    localparam logic [3:0] c_WR_LOAD = 4'(WR_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_READ     = 2'd1,
        S_WRITE    = 2'd2,
        S_PREFETCH = 2'd3
    } state_t;

    state_t                  r_state;
    logic [3:0]              r_cnt;
    logic                    r_wait;
    logic                    r_valid;
    logic [DMEM_WIDTH-1:0]   r_rdata;
    logic [DEPTH_LOG2-1:0]   r_idx;
    logic [DMEM_WIDTH-1:0]   r_wdata;
    logic [c_BYTES-1:0]      r_byteen;
    logic [DMEM_WIDTH-1:0]   r_mem [c_DEPTH];

    logic w_commit;
    logic w_unused_addr;

    // Commit only on the last busy cycle; a reset before that edge drops the write.
    assign w_commit      = (r_state == S_WRITE) && (r_cnt == 4'd1);
    assign w_unused_addr = ^dbus.dbus_address;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_wait   <= 1'b0;
            r_valid  <= 1'b0;
            r_rdata  <= '0;
            r_idx    <= '0;
            r_wdata  <= '0;
            r_byteen <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (dbus.dbus_en) begin
                        r_idx    <= dbus.dbus_address[c_OFFSET +: DEPTH_LOG2];
                        r_wdata  <= dbus.dbus_writedata;
                        r_byteen <= dbus.dbus_byteen;
                        r_wait   <= 1'b1;
                        if (dbus.dbus_wren) begin
                            r_state <= S_WRITE;
                            r_cnt   <= c_WR_LOAD;
                        end else if (dbus.dbus_prefetch) begin
                            r_state <= S_PREFETCH;
                            r_cnt   <= c_RD_LOAD;
                        end else begin
                            r_state <= S_READ;
                            r_cnt   <= c_RD_LOAD;
                        end
                    end
                end
                S_READ, S_PREFETCH: begin
                    // Counter reaches 0 in the response cycle, which is still busy-state.
                    if (r_cnt == 4'd1) begin
                        r_wait <= 1'b0;
                        r_cnt  <= 4'd0;
                        if (r_state == S_READ) begin
                            r_valid <= 1'b1;
                            r_rdata <= r_mem[r_idx];
                        end
                    end else if (r_cnt == 4'd0) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_WRITE: begin
                    if (r_cnt == 4'd1) begin
                        r_state <= S_IDLE;
                        r_wait  <= 1'b0;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int b = 0; b < c_BYTES; b++) begin
                if (r_byteen[b]) begin
                    r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    assign dbus.dbus_wait       = r_wait;
    assign dbus.dbus_data_valid = r_valid;
    assign dbus.dbus_readdata   = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dbus_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dbus_responder
//  Purpose  : Self-checking bench for dbus_responder: directed table, reset
//             corner cases and randomized traffic against a word-array model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dbus_responder;
    localparam int W  = 128;
    localparam int AW = 32;
    localparam int RL = 3;
    localparam int WL = 2;

    logic clk;
    logic resetn;

    dbus_responder_if #(.DMEM_WIDTH(W), .DMEM_ADDRWIDTH(AW)) bus ();

    dbus_responder #(
        .DMEM_WIDTH    (W),
        .DMEM_ADDRWIDTH(AW),
        .DEPTH_LOG2    (8),
        .RD_LATENCY    (RL),
        .WR_LATENCY    (WL)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .dbus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain word array plus the last word handed back.
    logic [W-1:0] m_mem [256];
    logic [W-1:0] last_rd;
    int n_checks;
    int n_pass;

    typedef struct {
        logic         wr;
        logic         pf;
        logic [31:0]  addr;
        logic [W-1:0] data;
        logic [15:0]  be;
        logic         has_exp;
        logic [W-1:0] exp;
    } vec_t;

    vec_t tbl [11];

    function automatic int widx(input logic [31:0] a);
        return int'(a[11:4]);
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Called just after a negedge with the DUT idle; returns after the first idle cycle.
    task automatic txn(input logic wr, input logic pf, input logic [31:0] addr,
                       input logic [W-1:0] data, input logic [15:0] be, input int dup);
        int lat;
        logic is_rd;
        logic [W-1:0] exp_rd;
        lat    = wr ? WL : RL;
        is_rd  = !wr && !pf;
        exp_rd = m_mem[widx(addr)];
        bus.dbus_en        = 1'b1;
        bus.dbus_wren      = wr;
        bus.dbus_prefetch  = pf;
        bus.dbus_address   = addr;
        bus.dbus_writedata = data;
        bus.dbus_byteen    = be;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            bus.dbus_en = (k == dup);
            if (k == dup) begin
                bus.dbus_wren      = 1'b1;
                bus.dbus_writedata = ~data;
                bus.dbus_byteen    = '1;
            end
            if (is_rd && k == lat) last_rd = exp_rd;
            chk("wait",  {127'd0, bus.dbus_wait},       {127'd0, (wr ? 1'b1 : (k < lat))});
            chk("valid", {127'd0, bus.dbus_data_valid}, {127'd0, (is_rd && k == lat)});
            chk("rdata", bus.dbus_readdata, last_rd);
        end
        if (wr) begin
            for (int b = 0; b < 16; b++)
                if (be[b]) m_mem[widx(addr)][8*b +: 8] = data[8*b +: 8];
        end
        @(negedge clk);
        bus.dbus_en = 1'b0;
        chk("idle_wait",  {127'd0, bus.dbus_wait},       '0);
        chk("idle_valid", {127'd0, bus.dbus_data_valid}, '0);
    endtask

    initial begin
        logic [W-1:0] d;
        logic [15:0]  be;
        logic         wr;
        int           dup;
        n_checks = 0;
        n_pass   = 0;
        last_rd  = '0;
        resetn   = 1'b0;
        bus.dbus_en = 1'b0; bus.dbus_wren = 1'b0; bus.dbus_prefetch = 1'b0;
        bus.dbus_address = '0; bus.dbus_writedata = '0; bus.dbus_byteen = '0;

        tbl[0]  = '{1'b1, 1'b0, 32'h40,        128'h0F0E0D0C0B0A09080706050403020100, 16'hFFFF, 1'b0, '0};
        tbl[1]  = '{1'b0, 1'b0, 32'h40,        '0, 16'h0, 1'b1, 128'h0F0E0D0C0B0A09080706050403020100};
        tbl[2]  = '{1'b0, 1'b1, 32'h100,       '0, 16'h0, 1'b1, 128'h0F0E0D0C0B0A09080706050403020100};
        tbl[3]  = '{1'b1, 1'b0, 32'h80,        '1, 16'hFFFF, 1'b0, '0};
        tbl[4]  = '{1'b1, 1'b0, 32'h80,        '0, 16'h00FF, 1'b0, '0};
        tbl[5]  = '{1'b0, 1'b0, 32'h80,        '0, 16'h0, 1'b1, 128'hFFFFFFFFFFFFFFFF0000000000000000};
        tbl[6]  = '{1'b1, 1'b0, 32'h80,        128'h123456789ABCDEF0123456789ABCDEF0, 16'h0000, 1'b0, '0};
        tbl[7]  = '{1'b0, 1'b0, 32'h80,        '0, 16'h0, 1'b1, 128'hFFFFFFFFFFFFFFFF0000000000000000};
        tbl[8]  = '{1'b1, 1'b0, 32'h1040,      128'hA5A5_0001_0002_0003_0004_0005_0006_C3C3, 16'hFFFF, 1'b0, '0};
        tbl[9]  = '{1'b0, 1'b0, 32'h40,        '0, 16'h0, 1'b1, 128'hA5A5_0001_0002_0003_0004_0005_0006_C3C3};
        tbl[10] = '{1'b0, 1'b0, 32'h1000_0048, '0, 16'h0, 1'b1, 128'hA5A5_0001_0002_0003_0004_0005_0006_C3C3};

        repeat (3) @(negedge clk);
        chk("rst_wait",  {127'd0, bus.dbus_wait},       '0);
        chk("rst_valid", {127'd0, bus.dbus_data_valid}, '0);
        chk("rst_rdata", bus.dbus_readdata, '0);
        resetn = 1'b1;
        @(negedge clk);

        // Give every word a known value so later reads compare fully.
        for (int i = 0; i < 256; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            txn(1'b1, 1'b0, 32'(i) << 4, d, 16'hFFFF, 0);
        end

        for (int i = 0; i < 11; i++) begin
            txn(tbl[i].wr, tbl[i].pf, tbl[i].addr, tbl[i].data, tbl[i].be, 0);
            if (tbl[i].has_exp) chk($sformatf("tbl%0d", i), bus.dbus_readdata, tbl[i].exp);
        end

        // Second request during a busy read is ignored; next read right after idle.
        txn(1'b0, 1'b0, 32'h40, '0, 16'h0, 2);
        txn(1'b0, 1'b0, 32'h40, '0, 16'h0, 0);
        chk("dup_ignored", bus.dbus_readdata, 128'hA5A5_0001_0002_0003_0004_0005_0006_C3C3);

        // Reset in the cycle before a write commit aborts the write.
        bus.dbus_en = 1'b1; bus.dbus_wren = 1'b1; bus.dbus_prefetch = 1'b0;
        bus.dbus_address = 32'h80; bus.dbus_writedata = 128'hDEAD; bus.dbus_byteen = 16'hFFFF;
        for (int k = 1; k < WL; k++) begin
            @(negedge clk);
            bus.dbus_en = 1'b0;
            chk("wrabort_busy", {127'd0, bus.dbus_wait}, {127'd0, 1'b1});
        end
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("wrabort_wait",  {127'd0, bus.dbus_wait}, '0);
        chk("wrabort_rdata", bus.dbus_readdata, '0);
        last_rd = '0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        txn(1'b0, 1'b0, 32'h80, '0, 16'h0, 0);
        chk("wrabort_old", bus.dbus_readdata, 128'hFFFFFFFFFFFFFFFF0000000000000000);

        // Reset during a read: no valid pulse, next read is normal.
        bus.dbus_en = 1'b1; bus.dbus_wren = 1'b0; bus.dbus_address = 32'h40;
        @(negedge clk);
        bus.dbus_en = 1'b0;
        resetn = 1'b0;
        #1;
        chk("rdabort_wait", {127'd0, bus.dbus_wait}, '0);
        last_rd = '0;
        for (int k = 0; k < RL; k++) begin
            @(negedge clk);
            chk("rdabort_valid", {127'd0, bus.dbus_data_valid}, '0);
        end
        resetn = 1'b1;
        @(negedge clk);
        chk("rdabort_rdata", bus.dbus_readdata, '0);
        txn(1'b0, 1'b0, 32'h40, '0, 16'h0, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            wr = 1'($urandom_range(0, 1));
            d  = {$urandom, $urandom, $urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       be = 16'h0000;
                1:       be = 16'hFFFF;
                default: be = 16'($urandom);
            endcase
            dup = ($urandom_range(0, 7) == 0) ? (wr ? $urandom_range(1, WL - 1) : $urandom_range(1, RL - 1)) : 0;
            txn(wr, 1'($urandom_range(0, 1)), $urandom, d, be, dup);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dbus_responder.md
DBUS_RESPONDER -- requirements
Module: dbus_responder

Interface
REQ-001 SHALL have parameter DMEM_WIDTH, default 128, data bus width in bits.
REQ-002 SHALL have parameter DMEM_ADDRWIDTH, default 32, byte address width.
REQ-003 SHALL have parameter DEPTH_LOG2, default 8, log2 of internal memory depth in DMEM_WIDTH-bit words.
REQ-004 SHALL have parameter RD_LATENCY, default 3, legal range 2..15, cycles from request acceptance to data return.
REQ-005 SHALL have parameter WR_LATENCY, default 2, legal range 1..15, cycles dbus_wait is held for a write.
REQ-006 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-007 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port dbus_address  input  DMEM_ADDRWIDTH  byte address of the request.
REQ-009 SHALL have port dbus_writedata  input  DMEM_WIDTH  write data.
REQ-010 SHALL have port dbus_byteen  input  DMEM_WIDTH/8  per-byte write enable; bit k covers bits 8k+7:8k.
REQ-011 SHALL have port dbus_en  input  1  request strobe.
REQ-012 SHALL have port dbus_wren  input  1  1 = write, 0 = read; sampled with dbus_en.
REQ-013 SHALL have port dbus_prefetch  input  1  prefetch hint; sampled with dbus_en when dbus_wren=0.
REQ-014 SHALL have port dbus_wait  output  1  responder busy; initiator holds off.
REQ-015 SHALL have port dbus_data_valid  output  1  one-cycle pulse qualifying dbus_readdata.
REQ-016 SHALL have port dbus_readdata  output  DMEM_WIDTH  read data.

Function
REQ-017 SHALL hold 2^DEPTH_LOG2 words of DMEM_WIDTH bits; word index = dbus_address[LOG2(DMEM_WIDTH/8) +: DEPTH_LOG2]; low byte-offset bits and upper bits ignored (address wraps modulo depth).
REQ-018 SHALL implement FSM states IDLE, READ, WRITE, PREFETCH plus a latency down-counter.
REQ-019 SHALL accept a request only on a rising edge where state=IDLE and dbus_en=1, latching address, wren, prefetch, writedata and byteen; dbus_en in any other state SHALL be ignored with no side effect.
REQ-020 IDLE: dbus_wait=0, dbus_data_valid=0; accepted dbus_wren=1 -> WRITE; dbus_wren=0, dbus_prefetch=0 -> READ; dbus_wren=0, dbus_prefetch=1 -> PREFETCH; wren=1 takes priority over prefetch.
REQ-021 READ accepted at edge t: dbus_wait=1 during cycles t+1..t+RD_LATENCY-1; in cycle t+RD_LATENCY dbus_wait=0, dbus_data_valid=1, dbus_readdata=addressed word; state IDLE from t+RD_LATENCY+1.
REQ-022 Read data SHALL reflect all writes completed before the accepting edge.
REQ-023 dbus_readdata SHALL hold the last returned word outside valid cycles (0 after reset).
REQ-024 WRITE accepted at edge t: dbus_wait=1 during cycles t+1..t+WR_LATENCY; memory bytes with byteen=1 updated at the edge ending cycle t+WR_LATENCY, bytes with byteen=0 unchanged; IDLE from t+WR_LATENCY+1 with dbus_wait=0.
REQ-025 byteen all zero SHALL complete with normal write timing and leave memory unchanged.
REQ-026 PREFETCH SHALL follow READ timing exactly but never assert dbus_data_valid and never change dbus_readdata.
REQ-027 dbus_data_valid SHALL be high for exactly one cycle per READ and never simultaneously with dbus_wait.
REQ-028 A new request SHALL be acceptable at the first IDLE edge after completion (no extra bubble).
REQ-029 Memory contents SHALL not be reset or initialised.

Reset
REQ-030 resetn=0 SHALL immediately force state IDLE, counter 0, dbus_wait=0, dbus_data_valid=0, dbus_readdata=0.
REQ-031 Reset during WRITE before its commit edge SHALL abort the write; memory unchanged.
REQ-032 Reset during READ SHALL abort with no data_valid pulse; first request after resetn rises SHALL be accepted normally.

Verification
REQ-033 Write addr 0x40, data 0x0F..00 pattern, byteen 0xFFFF; then read 0x40 -> wait high 2 cycles, data_valid in 3rd cycle with same pattern.
REQ-034 Write all-ones to 0x80, then write 0x0 with byteen 0x00FF -> read 0x80 returns upper 8 bytes 0xFF, lower 8 bytes 0x00.
REQ-035 Pulse dbus_en for a second read while first READ busy -> ignored; exactly one data_valid; next en at completion+1 accepted.
REQ-036 Prefetch request at 0x100 -> wait high 2 cycles, no data_valid, readdata unchanged; write to addr 0x1040 with DEPTH_LOG2=8 aliases word 4 (0x40).
REQ-037 Assert resetn=0 in the cycle before a write commit -> wait drops immediately, subsequent read of that address returns old data.
